// File: rtl/screen_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : screen_ctrl
//  Purpose  : START -> GAME -> OVER screen sequencer for the plane-war game.
//             Debounces the start button, queues at most one screen request,
//             applies it only at a frame boundary of the displayed source and
//             drives the VGA pins from the selected screen block.
//  Revision : 1.0  initial release
// ============================================================================
module screen_ctrl #(
    parameter int DEBOUNCE_CYCLES  = 251750,
    parameter int GAME_RST_CYCLES  = 16,
    parameter int OVER_HOLD_FRAMES = 180
) (
    input  logic        vga_clk,
    input  logic        rst,
    input  logic        btn_raw,
    input  logic        player_dead,
    input  logic [11:0] s_rgb,
    input  logic        s_hs,
    input  logic        s_vs,
    input  logic [11:0] g_rgb,
    input  logic        g_hs,
    input  logic        g_vs,
    input  logic [11:0] o_rgb,
    input  logic        o_hs,
    input  logic        o_vs,
    output logic [3:0]  red,
    output logic [3:0]  green,
    output logic [3:0]  blue,
    output logic        hs,
    output logic        vs,
    output logic        start_ena,
    output logic        game_ena,
    output logic        over_ena,
    output logic        game_rst,
    output logic [1:0]  state
);

    typedef enum logic [1:0] {
        ST_START = 2'd0,
        ST_GAME  = 2'd1,
        ST_OVER  = 2'd2,
        ST_BAD   = 2'd3
    } state_t;

    localparam logic [19:0] c_deb_last = 20'(DEBOUNCE_CYCLES - 1);
    localparam logic [7:0]  c_hold_max = 8'(OVER_HOLD_FRAMES);
    localparam logic [4:0]  c_grst_len = 5'(GAME_RST_CYCLES);

    // button path
    logic        sync1_q, sync1_d;
    logic        sync2_q, sync2_d;
    logic [19:0] deb_cnt_q, deb_cnt_d;
    logic        btn_stable_q, btn_stable_d;
    logic        btn_press;

    // frame boundary detection
    logic [11:0] sel_rgb;
    logic        sel_hs, sel_vs;
    logic        vs_prev_q, vs_prev_d;
    logic        frame_tick;

    // sequencer
    state_t      state_q, state_d;
    logic        pend_valid_q, pend_valid_d;
    state_t      pend_state_q, pend_state_d;
    logic [7:0]  hold_cnt_q, hold_cnt_d;
    logic [4:0]  grst_cnt_q, grst_cnt_d;

    // registered outputs
    logic        start_ena_q, start_ena_d;
    logic        game_ena_q, game_ena_d;
    logic        over_ena_q, over_ena_d;
    logic        game_rst_q, game_rst_d;
    logic [11:0] rgb_q, rgb_d;
    logic        hs_q, hs_d;
    logic        vs_q, vs_d;

    // Synchronise and debounce the button; a press is the accepted 0->1 level change.
    always_comb begin
        sync1_d      = btn_raw;
        sync2_d      = sync1_q;
        deb_cnt_d    = deb_cnt_q;
        btn_stable_d = btn_stable_q;
        btn_press    = 1'b0;
        if (sync2_q == btn_stable_q) begin
            deb_cnt_d = '0;
        end else if (deb_cnt_q == c_deb_last) begin
            btn_stable_d = sync2_q;
            deb_cnt_d    = '0;
            btn_press    = sync2_q;
        end else begin
            deb_cnt_d = deb_cnt_q + 20'd1;
        end
    end

    // Pick the bundle of the screen currently shown; an illegal state shows black.
    always_comb begin
        sel_rgb = 12'h000;
        sel_hs  = 1'b1;
        sel_vs  = 1'b1;
        case (state_q)
            ST_START: begin sel_rgb = s_rgb; sel_hs = s_hs; sel_vs = s_vs; end
            ST_GAME:  begin sel_rgb = g_rgb; sel_hs = g_hs; sel_vs = g_vs; end
            ST_OVER:  begin sel_rgb = o_rgb; sel_hs = o_hs; sel_vs = o_vs; end
            default:  begin sel_rgb = 12'h000; sel_hs = 1'b1; sel_vs = 1'b1; end
        endcase
    end

    // Frame boundary is the falling edge of the displayed source's vsync.
    assign vs_prev_d  = sel_vs;
    assign frame_tick = vs_prev_q & ~sel_vs;

    // Hold one request and apply it only at a frame boundary so frames are never torn.
    always_comb begin
        state_d      = state_q;
        pend_valid_d = pend_valid_q;
        pend_state_d = pend_state_q;
        hold_cnt_d   = hold_cnt_q;
        if (state_q == ST_BAD) begin
            state_d      = ST_START;
            pend_valid_d = 1'b0;
            hold_cnt_d   = '0;
        end else if (frame_tick && pend_valid_q) begin
            state_d      = pend_state_q;
            pend_valid_d = 1'b0;
            hold_cnt_d   = '0;
        end else begin
            if (frame_tick && (state_q == ST_OVER) && (hold_cnt_q != c_hold_max)) begin
                hold_cnt_d = hold_cnt_q + 8'd1;
            end
            // a request raised here is only seen by the next frame_tick
            if (!pend_valid_q) begin
                case (state_q)
                    ST_START: if (btn_press) begin
                        pend_valid_d = 1'b1;
                        pend_state_d = ST_GAME;
                    end
                    ST_GAME: if (player_dead) begin
                        pend_valid_d = 1'b1;
                        pend_state_d = ST_OVER;
                    end
                    ST_OVER: if (btn_press && (hold_cnt_q == c_hold_max)) begin
                        pend_valid_d = 1'b1;
                        pend_state_d = ST_START;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Keep game logic in reset outside GAME and for a short window after entering it.
    always_comb begin
        if (state_q != ST_GAME) begin
            grst_cnt_d = '0;
        end else if (grst_cnt_q != c_grst_len) begin
            grst_cnt_d = grst_cnt_q + 5'd1;
        end else begin
            grst_cnt_d = grst_cnt_q;
        end
        game_rst_d = (state_d != ST_GAME) || (grst_cnt_d != c_grst_len);
    end

    // Enables cover the pending screen too, so its ROM warms up before the switch.
    always_comb begin
        start_ena_d = (state_d == ST_START) || (pend_valid_d && (pend_state_d == ST_START));
        game_ena_d  = (state_d == ST_GAME)  || (pend_valid_d && (pend_state_d == ST_GAME));
        over_ena_d  = (state_d == ST_OVER)  || (pend_valid_d && (pend_state_d == ST_OVER));
        rgb_d       = sel_rgb;
        hs_d        = sel_hs;
        vs_d        = sel_vs;
    end

    // All state and output registers; async reset returns to the START screen.
    always_ff @(posedge vga_clk or posedge rst) begin
        if (rst) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            deb_cnt_q    <= '0;
            btn_stable_q <= 1'b0;
            vs_prev_q    <= 1'b1;
            state_q      <= ST_START;
            pend_valid_q <= 1'b0;
            pend_state_q <= ST_START;
            hold_cnt_q   <= '0;
            grst_cnt_q   <= '0;
            start_ena_q  <= 1'b1;
            game_ena_q   <= 1'b0;
            over_ena_q   <= 1'b0;
            game_rst_q   <= 1'b1;
            rgb_q        <= 12'h000;
            hs_q         <= 1'b1;
            vs_q         <= 1'b1;
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            deb_cnt_q    <= deb_cnt_d;
            btn_stable_q <= btn_stable_d;
            vs_prev_q    <= vs_prev_d;
            state_q      <= state_d;
            pend_valid_q <= pend_valid_d;
            pend_state_q <= pend_state_d;
            hold_cnt_q   <= hold_cnt_d;
            grst_cnt_q   <= grst_cnt_d;
            start_ena_q  <= start_ena_d;
            game_ena_q   <= game_ena_d;
            over_ena_q   <= over_ena_d;
            game_rst_q   <= game_rst_d;
            rgb_q        <= rgb_d;
            hs_q         <= hs_d;
            vs_q         <= vs_d;
        end
    end

    assign red       = rgb_q[11:8];
    assign green     = rgb_q[7:4];
    assign blue      = rgb_q[3:0];
    assign hs        = hs_q;
    assign vs        = vs_q;
    assign start_ena = start_ena_q;
    assign game_ena  = game_ena_q;
    assign over_ena  = over_ena_q;
    assign game_rst  = game_rst_q;
    assign state     = state_q;

endmodule
`default_nettype wire

// File: tb/tb_screen_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_screen_ctrl
//  Purpose  : Scoreboard bench for screen_ctrl. A behavioural model predicts
//             the pins every cycle; a monitor compares them at the falling edge.
//  Revision : 1.0  initial release
// ============================================================================
module tb_screen_ctrl;

    localparam int D    = 4;
    localparam int GR   = 16;
    localparam int HOLD = 3;
    localparam int PER  = 30;   // frame length of every source, in cycles
    localparam int VSW  = 3;    // vsync low width
    localparam int PH_S = 0;
    localparam int PH_G = 11;
    localparam int PH_O = 19;

    logic        vga_clk = 1'b0;
    logic        rst = 1'b1;
    logic        btn_raw = 1'b0;
    logic        player_dead = 1'b0;
    logic [11:0] s_rgb = 12'h0, g_rgb = 12'h0, o_rgb = 12'h0;
    logic        s_hs = 1'b1, s_vs = 1'b1, g_hs = 1'b1, g_vs = 1'b1, o_hs = 1'b1, o_vs = 1'b1;
    logic [3:0]  red, green, blue;
    logic        hs, vs, start_ena, game_ena, over_ena, game_rst;
    logic [1:0]  state;

    screen_ctrl #(
        .DEBOUNCE_CYCLES (D),
        .GAME_RST_CYCLES (GR),
        .OVER_HOLD_FRAMES(HOLD)
    ) dut (
        .vga_clk    (vga_clk),
        .rst        (rst),
        .btn_raw    (btn_raw),
        .player_dead(player_dead),
        .s_rgb      (s_rgb),
        .s_hs       (s_hs),
        .s_vs       (s_vs),
        .g_rgb      (g_rgb),
        .g_hs       (g_hs),
        .g_vs       (g_vs),
        .o_rgb      (o_rgb),
        .o_hs       (o_hs),
        .o_vs       (o_vs),
        .red        (red),
        .green      (green),
        .blue       (blue),
        .hs         (hs),
        .vs         (vs),
        .start_ena  (start_ena),
        .game_ena   (game_ena),
        .over_ena   (over_ena),
        .game_rst   (game_rst),
        .state      (state)
    );

    always #5 vga_clk = ~vga_clk;

    // scoreboard: {state, start_ena, game_ena, over_ena, game_rst, rgb, hs, vs}
    logic [19:0] sb[$];
    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;

    // reference model: screen in terms of events, run lengths and elapsed time
    int          m_state;        // 0 START, 1 GAME, 2 OVER
    int          m_pend;         // -1 when nothing is pending
    bit          m_stable;       // accepted button level
    int          m_run;          // consecutive cycles the synced button disagreed
    bit          m_hist[$];      // raw button samples still inside the synchronizer
    bit          m_prev_vs;      // displayed vsync one cycle ago
    int          m_over_ticks;   // frames shown since entering OVER
    int          m_game_cycles;  // cycles spent in GAME since entering it
    logic [13:0] m_pins;         // {rgb, hs, vs} currently on the pins

    function automatic void model_reset();
        m_state = 0;
        m_pend = -1;
        m_stable = 1'b0;
        m_run = 0;
        m_hist.delete();
        m_hist.push_back(1'b0);
        m_hist.push_back(1'b0);
        m_prev_vs = 1'b1;
        m_over_ticks = 0;
        m_game_cycles = 0;
        m_pins = {12'h000, 1'b1, 1'b1};
    endfunction

    function automatic logic [19:0] model_expect();
        return {2'(m_state),
                (m_state == 0) || (m_pend == 0),
                (m_state == 1) || (m_pend == 1),
                (m_state == 2) || (m_pend == 2),
                (m_state != 1) || (m_game_cycles < GR),
                m_pins};
    endfunction

    function automatic void model_step();
        bit          sync, press, tick;
        logic [13:0] sel;
        sync = m_hist.pop_front();
        m_hist.push_back(btn_raw);
        press = 1'b0;
        if (sync != m_stable) begin
            m_run++;
            if (m_run >= D) begin
                m_stable = sync;
                m_run = 0;
                press = sync;
            end
        end else begin
            m_run = 0;
        end
        case (m_state)
            0:       sel = {s_rgb, s_hs, s_vs};
            1:       sel = {g_rgb, g_hs, g_vs};
            2:       sel = {o_rgb, o_hs, o_vs};
            default: sel = {12'h000, 1'b1, 1'b1};
        endcase
        tick = m_prev_vs && !sel[0];
        m_prev_vs = sel[0];
        m_pins = sel;
        if (m_state == 1) m_game_cycles++;
        if (tick && m_pend >= 0) begin
            m_state = m_pend;
            m_pend = -1;
            m_over_ticks = 0;
            m_game_cycles = 0;
        end else begin
            if (m_pend < 0) begin
                if (m_state == 0 && press) m_pend = 1;
                else if (m_state == 1 && player_dead) m_pend = 2;
                else if (m_state == 2 && press && m_over_ticks >= HOLD) m_pend = 0;
            end
            if (tick && m_state == 2) m_over_ticks++;
        end
    endfunction

    // drive one cycle of stimulus and push the pins expected during it
    task automatic cycle(input bit r, input bit b, input bit d);
        @(posedge vga_clk);
        #1;
        cyc++;
        rst         = r;
        btn_raw     = b;
        player_dead = d;
        s_vs  = (((cyc + PH_S) % PER) >= VSW);
        g_vs  = (((cyc + PH_G) % PER) >= VSW);
        o_vs  = (((cyc + PH_O) % PER) >= VSW);
        s_hs  = 1'($urandom);
        g_hs  = 1'($urandom);
        o_hs  = 1'($urandom);
        s_rgb = 12'($urandom);
        g_rgb = 12'($urandom);
        o_rgb = 12'($urandom);
        if (r) model_reset();
        sb.push_back(model_expect());
        if (!r) model_step();
    endtask

    // monitor: compare the pins against the scoreboard at each falling edge
    initial begin : monitor
        logic [19:0] exp_v, act_v;
        forever begin
            @(negedge vga_clk);
            if (sb.size() > 0) begin
                exp_v = sb.pop_front();
                act_v = {state, start_ena, game_ena, over_ena, game_rst,
                         red, green, blue, hs, vs};
                n_vec++;
                if (act_v !== exp_v) begin
                    n_bad++;
                    $display("FAIL cycle %0d pins: got %h expected %h", cyc, act_v, exp_v);
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int len;
        int gap;
        model_reset();
        repeat (3) cycle(1'b1, 1'b0, 1'b0);
        repeat (20) cycle(1'b0, 1'b0, 1'b0);
        // glitch shorter than the debounce window
        repeat (3) cycle(1'b0, 1'b1, 1'b0);
        repeat (20) cycle(1'b0, 1'b0, 1'b0);
        // genuine press: START -> GAME
        repeat (10) cycle(1'b0, 1'b1, 1'b0);
        repeat (80) cycle(1'b0, 1'b0, 1'b0);
        // two deaths five cycles apart: one switch to OVER
        cycle(1'b0, 1'b0, 1'b1);
        repeat (4) cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b1);
        repeat (80) cycle(1'b0, 1'b0, 1'b0);
        // early press in OVER is discarded
        repeat (10) cycle(1'b0, 1'b1, 1'b0);
        repeat (10) cycle(1'b0, 1'b0, 1'b0);
        repeat (130) cycle(1'b0, 1'b0, 1'b0);
        // press after the hold: OVER -> START
        repeat (10) cycle(1'b0, 1'b1, 1'b0);
        repeat (80) cycle(1'b0, 1'b0, 1'b0);
        // press accepted exactly on a start-screen frame boundary
        while (((cyc + 6 + PH_S) % PER) != 0) cycle(1'b0, 1'b0, 1'b0);
        repeat (10) cycle(1'b0, 1'b1, 1'b0);
        repeat (100) cycle(1'b0, 1'b0, 1'b0);
        // random presses, deaths and one mid-operation reset
        for (int i = 0; i < 80; i++) begin
            len = $urandom_range(1, 12);
            gap = $urandom_range(2, 40);
            if (i == 40) repeat (2) cycle(1'b1, 1'b0, 1'b0);
            repeat (len) cycle(1'b0, 1'b1, 1'b0);
            for (int k = 0; k < gap; k++) cycle(1'b0, 1'b0, ($urandom_range(0, 15) == 0));
        end
        repeat (3) cycle(1'b0, 1'b0, 1'b0);
        @(negedge vga_clk);
        @(negedge vga_clk);
        n_vec++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard drain: got %0d entries left, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/screen_ctrl.md
# screen_ctrl

Top-level screen sequencer for the plane-war game. It owns the START → GAME → OVER flow, enables exactly the screen blocks that are needed, and debounces the start button. It muxes the RGB and sync outputs of the start, game and over screen blocks onto the VGA pins. Screen switches happen only at frame boundaries, so the monitor never sees a torn frame.

## Interface
Parameters:
- DEBOUNCE_CYCLES, 251750 — stable-input cycles required to accept a button level (10 ms at 25.175 MHz)
- GAME_RST_CYCLES, 16 — length of game_rst pulse after entering GAME
- OVER_HOLD_FRAMES, 180 — frames OVER must be shown before button may return to START

Ports:
- vga_clk  in  1  pixel clock, 25.175 MHz
- rst  in  1  asynchronous, active-high reset
- btn_raw  in  1  raw start button, asynchronous, active-high
- player_dead  in  1  1-cycle pulse from game logic, vga_clk domain
- s_rgb  in  12  start screen {red,green,blue}
- s_hs, s_vs  in  1  start screen syncs, active-low
- g_rgb  in  12  game screen {red,green,blue}
- g_hs, g_vs  in  1  game screen syncs, active-low
- o_rgb  in  12  over screen {red,green,blue}
- o_hs, o_vs  in  1  over screen syncs, active-low
- red, green, blue  out  4 each  VGA colour
- hs, vs  out  1  VGA syncs
- start_ena, game_ena, over_ena  out  1  screen block enables
- game_rst  out  1  active-high reset to game logic
- state  out  2  0=START, 1=GAME, 2=OVER

## Operation
- Button path:
  - 2-FF synchronizer → btn_sync.
  - 20-bit debounce counter clears whenever btn_sync == btn_stable. Otherwise it increments.
  - When the counter reaches DEBOUNCE_CYCLES-1, btn_stable <= btn_sync and the counter clears.
  - btn_press is a 1-cycle pulse on a btn_stable 0→1 transition.
- frame_tick: 1-cycle pulse when the selected source's vs is 0 and vs_prev is 1. vs_prev is a register sampling the selected vs every cycle.
- Requests: at most one pending request is held (pending_valid, pending_state).
  - START and btn_press → request GAME.
  - GAME and player_dead → request OVER. btn_press is ignored in GAME.
  - OVER and btn_press and hold_cnt == OVER_HOLD_FRAMES → request START. An earlier press is discarded, not queued.
  - While pending_valid is set, all further events are ignored.
- Apply: on frame_tick with pending_valid set, state <= pending_state, pending_valid <= 0, hold_cnt <= 0.
  - A request raised in the same cycle as a frame_tick is applied at the next frame_tick, not the current one.
- hold_cnt: 8-bit, increments on frame_tick while in OVER, saturates at OVER_HOLD_FRAMES.
- Enables: X_ena = (state==X) | (pending_valid & pending_state==X). This gives the incoming screen's ROM a warm-up period.
- game_rst: high whenever state != GAME.
  - On entering GAME it stays high for GAME_RST_CYCLES further cycles, then drops.
  - A 5-bit counter times this window.
- Output mux: registered. It selects the {rgb, hs, vs} bundle of the current state.
  - state==3 is unreachable; if it ever occurs, outputs are black with hs=vs=1 and the next clock forces START.
- Reset values:
  - state=0, pending_valid=0, hold_cnt=0, btn_stable=0, debounce counter 0.
  - red=green=blue=0, hs=1, vs=1.
  - start_ena=1, game_ena=0, over_ena=0, game_rst=1.
- Reset mid-operation: everything returns immediately to the reset values and any pending request is lost.

## Timing
- Colour/sync latency: 1 cycle from the selected input to the output pins.
- Button latency:
  - 2 sync cycles + DEBOUNCE_CYCLES cycles from a stable btn_raw edge to btn_press.
  - The request latches on the same edge btn_press is seen.
- Switch, with frame_tick in cycle N:
  - state updates at the end of cycle N.
  - Pins carry the new source from the end of cycle N+1.
  - A switch therefore always occurs inside the old source's vsync pulse.
- game_rst after a GAME switch at the end of cycle N: stays high through cycle N+GAME_RST_CYCLES and is low from cycle N+GAME_RST_CYCLES+1.
- Glitches on btn_raw shorter than DEBOUNCE_CYCLES never produce btn_press.

## Test plan
- Reset: assert rst mid-frame → next cycle state=0, start_ena=1, game_ena=0, game_rst=1, hs=vs=1, rgb=0.
- Start, with DEBOUNCE_CYCLES=4:
  - Hold btn_raw high 10 cycles → one btn_press, game_ena=1 immediately.
  - At the next s_vs falling edge, state=1.
  - game_rst falls 16 cycles later.
  - Pins show g_rgb=12'hABC one cycle after the switch.
- Glitch: with DEBOUNCE_CYCLES=4, a 3-cycle btn_raw pulse → no btn_press and state stays 0.
- Death: in GAME, pulse player_dead with a second pulse 5 cycles later → a single switch to state=2 at the next g_vs falling edge. over_ena=1 and game_ena=0 after the switch.
- Over hold, with OVER_HOLD_FRAMES=3:
  - btn press after 1 frame → ignored.
  - btn press after 3 frames → state=0 at the following o_vs fall.
- Coincidence: a request raised in the same cycle as frame_tick → applied one full frame later, not immediately.
